// File: rtl/clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clock_gate_ctrl
//
// Enable-side controller for the integrated clock gate. Runs on the
// free-running clock. It watches for idle periods, asks the downstream domain
// to quiesce through sleep_req/sleep_ack, closes the gate once the request is
// accepted, and reopens it on wake or activity. clk_ready reports that the
// gated clock has been running long enough to be considered stable.
//
// Handshake: sleep_req is a level held high for as long as the controller
// sits in SLEEP. The downstream answers with sleep_ack. The ack is only
// sampled while sleep_req is high, on a rising clk_in edge. A request ends in
// one of three ways: it is withdrawn (wake), it is accepted (ack), or it
// times out (ack_timeout pulses for one cycle).
//
// Ports:
//   clk_in      in   free-running clock
//   rst_n       in   asynchronous active-low reset
//   activity    in   downstream busy indication
//   wake_req    in   explicit wake request (level or pulse)
//   test_mode   in   DFT override, forces the gate open
//   sleep_ack   in   downstream accepts the sleep request
//   gate_en     out  enable to clock_gate (registered enable OR test_mode)
//   clk_ready   out  gated clock running and stable
//   sleep_req   out  request to downstream to quiesce
//   ack_timeout out  one-cycle pulse when a sleep handshake times out
//   state       out  GATED=0, WAKE=1, RUN=2, SLEEP=3
// -----------------------------------------------------------------------------
module clock_gate_ctrl #(
   parameter int IDLE_CYCLES   = 16,
   parameter int WAKE_CYCLES   = 4,
   parameter int ACK_TIMEOUT   = 64,
   parameter bit START_ENABLED = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       activity,
   input  logic       wake_req,
   input  logic       test_mode,
   input  logic       sleep_ack,
   output logic       gate_en,
   output logic       clk_ready,
   output logic       sleep_req,
   output logic       ack_timeout,
   output logic [1:0] state
);

   localparam int MAX_AB = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int MAX_C  = (MAX_AB > ACK_TIMEOUT) ? MAX_AB : ACK_TIMEOUT;
   localparam int CW     = $clog2(MAX_C + 1);

   // Terminal counts; the IDLE value is unused when auto-gating is disabled.
   localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
   localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_GATED = 2'd0,
      ST_WAKE  = 2'd1,
      ST_RUN   = 2'd2,
      ST_SLEEP = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            first_q;        // high only during the first cycle after reset
   logic            gate_en_q, gate_en_d;
   logic            clk_ready_q, clk_ready_d;
   logic            sleep_req_q, sleep_req_d;
   logic            ack_timeout_q, ack_timeout_d;
   logic            timeout_hit;
   logic            wake;

   assign wake = activity | wake_req | test_mode;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_GATED;
         cnt_q         <= '0;
         first_q       <= 1'b1;
         gate_en_q     <= 1'b0;
         clk_ready_q   <= 1'b0;
         sleep_req_q   <= 1'b0;
         ack_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         first_q       <= 1'b0;
         gate_en_q     <= gate_en_d;
         clk_ready_q   <= clk_ready_d;
         sleep_req_q   <= sleep_req_d;
         ack_timeout_q <= ack_timeout_d;
      end
   end

   // --------------------------------------------------------------- next state
   // The shared counter is cleared on every transition, so each state starts
   // counting from zero.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
      case (state_q)
         ST_GATED: begin
            if (wake || (START_ENABLED && first_q)) begin
               state_d = ST_WAKE;
               cnt_d   = '0;
            end
         end
         ST_WAKE: begin
            // Wake inputs are irrelevant here; the gate is simply held open.
            if (cnt_q == WAKE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RUN: begin
            if (wake) begin
               cnt_d = '0;
            end else if (IDLE_CYCLES != 0) begin
               if (cnt_q == IDLE_LAST) begin
                  state_d = ST_SLEEP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_SLEEP: begin
            // Wake outranks ack so a simultaneous ack+activity aborts.
            if (wake) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (sleep_ack) begin
               state_d = ST_GATED;
               cnt_d   = '0;
            end else if (cnt_q == ACK_LAST) begin
               state_d     = ST_RUN;
               cnt_d       = '0;
               timeout_hit = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_GATED;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Registered outputs are decoded from the next state, so they change on
   // the same edge as the state. The gate only closes on entry to GATED,
   // which is reachable only from SLEEP (or reset).
   always_comb begin
      gate_en_d     = (state_d != ST_GATED);
      clk_ready_d   = (state_d == ST_RUN);
      sleep_req_d   = (state_d == ST_SLEEP);
      ack_timeout_d = timeout_hit;
   end

   assign gate_en     = gate_en_q | test_mode;
   assign clk_ready   = clk_ready_q;
   assign sleep_req   = sleep_req_q;
   assign ack_timeout = ack_timeout_q;
   assign state       = state_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_gate_ctrl
//
// Directed bench for clock_gate_ctrl with default parameters
// (IDLE_CYCLES=16, WAKE_CYCLES=4, ACK_TIMEOUT=64, START_ENABLED=1).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_clock_gate_ctrl;

   localparam logic [1:0] S_GATED = 2'd0;
   localparam logic [1:0] S_WAKE  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_SLEEP = 2'd3;

   logic       clk_in;
   logic       rst_n;
   logic       activity;
   logic       wake_req;
   logic       test_mode;
   logic       sleep_ack;
   logic       gate_en;
   logic       clk_ready;
   logic       sleep_req;
   logic       ack_timeout;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   clock_gate_ctrl dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .activity    (activity),
      .wake_req    (wake_req),
      .test_mode   (test_mode),
      .sleep_ack   (sleep_ack),
      .gate_en     (gate_en),
      .clk_ready   (clk_ready),
      .sleep_req   (sleep_req),
      .ack_timeout (ack_timeout),
      .state       (state)
   );

   // ------------------------------------------------------------ clock / reset
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // --------------------------------------------------------------- helpers
   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] st, input logic ge,
                          input logic cr, input logic sr, input logic at);
      chk({tag, ".state"},       {6'd0, state},       {6'd0, st});
      chk({tag, ".gate_en"},     {7'd0, gate_en},     {7'd0, ge});
      chk({tag, ".clk_ready"},   {7'd0, clk_ready},   {7'd0, cr});
      chk({tag, ".sleep_req"},   {7'd0, sleep_req},   {7'd0, sr});
      chk({tag, ".ack_timeout"}, {7'd0, ack_timeout}, {7'd0, at});
   endtask

   // -------------------------------------------------------------- stimulus
   initial begin
      rst_n     = 1'b0;
      activity  = 1'b0;
      wake_req  = 1'b0;
      test_mode = 1'b0;
      sleep_ack = 1'b0;

      #1;
      chk_all("reset", S_GATED, 0, 0, 0, 0);
      step(2);
      chk_all("reset_held", S_GATED, 0, 0, 0, 0);

      // Release: START_ENABLED opens the gate on the first edge.
      rst_n = 1'b1;
      step(1);
      chk_all("start_e1", S_WAKE, 1, 0, 0, 0);
      step(3);
      chk_all("start_e4", S_WAKE, 1, 0, 0, 0);
      step(1);
      chk_all("start_e5", S_RUN, 1, 1, 0, 0);

      // 16 idle cycles in RUN -> SLEEP on the 16th edge.
      step(15);
      chk_all("idle15", S_RUN, 1, 1, 0, 0);
      step(1);
      chk_all("idle16", S_SLEEP, 1, 0, 1, 0);

      // Ack three cycles into SLEEP closes the gate one edge later.
      step(2);
      chk_all("sleep_wait", S_SLEEP, 1, 0, 1, 0);
      sleep_ack = 1'b1;
      step(1);
      sleep_ack = 1'b0;
      chk_all("acked", S_GATED, 0, 0, 0, 0);
      step(3);
      chk_all("gated_stays", S_GATED, 0, 0, 0, 0);

      // One-cycle wake_req pulse reopens the gate.
      wake_req = 1'b1;
      step(1);
      wake_req = 1'b0;
      chk_all("wreq_e1", S_WAKE, 1, 0, 0, 0);
      step(3);
      chk_all("wreq_e4", S_WAKE, 1, 0, 0, 0);
      step(1);
      chk_all("wreq_e5", S_RUN, 1, 1, 0, 0);

      // sleep_ack outside SLEEP is ignored.
      activity  = 1'b1;
      sleep_ack = 1'b1;
      step(3);
      chk_all("ack_in_run", S_RUN, 1, 1, 0, 0);
      activity  = 1'b0;
      sleep_ack = 1'b0;

      // Idle again, then ack and activity together: activity wins.
      step(15);
      chk_all("idle2_15", S_RUN, 1, 1, 0, 0);
      step(1);
      chk_all("idle2_16", S_SLEEP, 1, 0, 1, 0);
      activity  = 1'b1;
      sleep_ack = 1'b1;
      step(1);
      activity  = 1'b0;
      sleep_ack = 1'b0;
      chk_all("ack_vs_act", S_RUN, 1, 1, 0, 0);

      // Idle into SLEEP, then no ack for 64 cycles -> timeout pulse.
      step(15);
      chk_all("idle3_15", S_RUN, 1, 1, 0, 0);
      step(1);
      chk_all("idle3_16", S_SLEEP, 1, 0, 1, 0);
      step(63);
      chk_all("to_63", S_SLEEP, 1, 0, 1, 0);
      step(1);
      chk_all("to_64", S_RUN, 1, 1, 0, 1);
      step(1);
      chk_all("to_after", S_RUN, 1, 1, 0, 0);
      step(14);
      chk_all("re_idle15", S_RUN, 1, 1, 0, 0);
      step(1);
      chk_all("re_idle16", S_SLEEP, 1, 0, 1, 0);

      // Reset mid-SLEEP: outputs drop without a clock edge.
      rst_n = 1'b0;
      #1;
      chk_all("rst_sleep", S_GATED, 0, 0, 0, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk_all("rel1_e1", S_WAKE, 1, 0, 0, 0);
      step(1);

      // Reset mid-WAKE, then a clean restart of the wake count.
      rst_n = 1'b0;
      #1;
      chk_all("rst_wake", S_GATED, 0, 0, 0, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk_all("rel2_e1", S_WAKE, 1, 0, 0, 0);
      step(3);
      chk_all("rel2_e4", S_WAKE, 1, 0, 0, 0);
      step(1);
      chk_all("rel2_e5", S_RUN, 1, 1, 0, 0);

      // Back to GATED, then test_mode opens the gate combinationally.
      step(16);
      chk_all("idle4_16", S_SLEEP, 1, 0, 1, 0);
      sleep_ack = 1'b1;
      step(1);
      sleep_ack = 1'b0;
      chk_all("acked2", S_GATED, 0, 0, 0, 0);
      test_mode = 1'b1;
      #1;
      chk_all("tm_comb", S_GATED, 1, 0, 0, 0);
      step(1);
      chk_all("tm_e1", S_WAKE, 1, 0, 0, 0);
      step(4);
      chk_all("tm_e5", S_RUN, 1, 1, 0, 0);
      // test_mode counts as wake, so no sleep request is ever raised.
      step(20);
      chk_all("tm_nosleep", S_RUN, 1, 1, 0, 0);
      test_mode = 1'b0;
      step(1);
      chk_all("tm_off", S_RUN, 1, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
